// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared types, constants and helpers for the instruction fetch queue
package ifetch_pkg;

    localparam int INS_W = 32;

    // Canonical no-op, optionally shown on ins_out while the queue head is empty
    localparam logic [INS_W-1:0] NOP_INS = 32'h0000_0013;

    // Idle head reads zero by default; set to 1'b1 to present NOP_INS instead
    localparam bit USE_NOP_IDLE = 1'b0;

    // Queue entry for the default 32-bit PC configuration
    typedef struct packed {
        logic [31:0]      pc;
        logic [INS_W-1:0] ins;
    } fetch_entry_t;

    // Ceiling log2 usable in constant expressions
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// rtl/ifq_fifo.sv - synchronous FIFO with flush, used as the fetch entry queue
module ifq_fifo
    import ifetch_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     sys_clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [clog2(DEPTH):0]    count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy tracking; clear discards everything in one edge
    always_ff @(posedge sys_clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset because count gates visibility
    always_ff @(posedge sys_clk) begin
        if (rst_n && !clear && do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction fetch unit: ROM issue, credit control, redirect and halt
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                ROM_AW   = 14,
    parameter int                QDEPTH   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] HALT_PC  = 32'h1000
) (
    input  logic                     sys_clk,
    input  logic                     rst_n,
    input  logic                     do_jump,
    input  logic [ADDR_W-1:0]        jump_addr,
    input  logic                     out_ready,
    output logic [ROM_AW-1:0]        rom_addr,
    output logic                     rom_en,
    input  logic [INS_W-1:0]         rom_data,
    output logic                     out_valid,
    output logic [INS_W-1:0]         ins_out,
    output logic [ADDR_W-1:0]        pc_out,
    output logic [ADDR_W-1:0]        next_pc_out,
    output logic [clog2(QDEPTH):0]   q_count,
    output logic                     halted
);

    localparam int QW = clog2(QDEPTH);
    localparam int EW = ADDR_W + INS_W;
    localparam logic [QW:0] LAST_SLOT = (QW+1)'(QDEPTH - 1);

    logic [ADDR_W-1:0] fpc;
    logic              inflight;
    logic [ADDR_W-1:0] tag;
    logic [EW-1:0]     fifo_dout;
    logic              fifo_empty;
    logic              fifo_full;
    logic              has_credit;
    logic              at_halt;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] head_pc;
    logic [INS_W-1:0]  head_ins;

    // A free slot must exist for the queued entries plus the word still on its way
    assign has_credit = ~fifo_full & ~(inflight & (q_count == LAST_SLOT));
    assign at_halt    = (fpc == HALT_PC);
    assign rom_en     = rst_n & ~do_jump & ~at_halt & has_credit;
    assign rom_addr   = fpc[ROM_AW+1:2];

    assign push = inflight & ~do_jump;
    assign pop  = out_valid & out_ready & ~do_jump;

    assign out_valid   = ~fifo_empty;
    assign head_pc     = fifo_dout[EW-1:INS_W];
    assign head_ins    = fifo_dout[INS_W-1:0];
    assign pc_out      = out_valid ? head_pc : '0;
    assign next_pc_out = out_valid ? head_pc + ADDR_W'(4) : '0;
    assign ins_out     = out_valid ? head_ins : (USE_NOP_IDLE ? NOP_INS : '0);
    assign halted      = rst_n & at_halt & fifo_empty & ~inflight;

    // Fetch PC and the single outstanding ROM read; redirect overrides sequential fetch
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            fpc      <= RESET_PC;
            inflight <= 1'b0;
            tag      <= '0;
        end else begin
            inflight <= rom_en;
            if (rom_en) tag <= fpc;
            if (do_jump) begin
                fpc <= jump_addr & ~ADDR_W'(3);
            end else if (rom_en) begin
                fpc <= fpc + ADDR_W'(4);
            end
        end
    end

    ifq_fifo #(
        .WIDTH (EW),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .clear   (do_jump),
        .din     ({tag, rom_data}),
        .dout    (fifo_dout),
        .count   (q_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

endmodule
